serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor: captures two WIDTH-bit operands on a start strobe and computes minuend − subtrahend one bit per clock, LSB first, through a 1-bit full subtractor with a registered borrow. It is the inverse arithmetic companion to the team's serial adder and uses the same start-driven operand interface, so both can sit side by side in the datapath. The result is presented as a WIDTH+1-bit word with the final borrow in the MSB, and a one-cycle done pulse.

## Interface

- WIDTH, 8, operand width in bits (≥ 2)
- clk  input  1  clock, rising-edge active
- reset  input  1  asynchronous, active-high
- start  input  1  request; sampled in IDLE or DONE
- operand1  input  WIDTH  minuend
- operand2  input  WIDTH  subtrahend
- busy  output  1  high while a subtraction is in progress (state RUN)
- done  output  1  one-cycle pulse; diff valid and updated
- diff  output  WIDTH+1  {borrow, difference}; held until next completion
- ovf  output  1  signed overflow flag (only with SERIAL_SUB_OVF_EN)

## Operation

- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1: capture operand1→A, operand2→B, borrow←0, bit count←0, result shift register←0; go to RUN. With start=0: IDLE stays IDLE; DONE goes to IDLE.
- RUN, each cycle, on a0=A[0], b0=B[0], br=borrow:
  - d = a0^b0^br
  - br' = (~a0&b0) | (~(a0^b0)&br)
  - A and B shift right; d shifts into the result MSB; count increments.
- RUN on the bit with count==WIDTH-1: diff ← {br', result with d}, done asserted next cycle, state goes to DONE.
- Arithmetic: diff equals the WIDTH+1-bit two's complement of {0,operand1} − {0,operand2}.
  - diff[WIDTH]=1 iff operand1 < operand2 (unsigned).
  - diff[WIDTH-1:0] = (operand1 − operand2) mod 2^WIDTH.
- start during RUN is ignored. Operand changes after capture are ignored.
- Back-to-back: start in DONE is accepted, so done and a new capture occur in the same cycle.

## Timing

- Reset values: state IDLE, busy=0, done=0, diff=0, ovf=0, internal registers 0.
- Reset is asynchronous and aborts any operation. No done is produced, and diff returns to 0.
- For start sampled at edge E0:
  - busy=1 from after E0 through edge E_WIDTH.
  - diff, ovf and done update at E_WIDTH.
  - done=1 for exactly the one cycle after E_WIDTH.
  - Latency is WIDTH+1 edges from sampling start to done falling. Start-to-result is WIDTH edges.
- busy and done are never high together.
- Throughput is one result per WIDTH+1 cycles when start is held high.

## Configuration

- SERIAL_SUB_OVF_EN defined:
  - The ovf port exists and is registered with diff.
  - ovf = (A_msb≠B_msb) && (d_msb≠A_msb), evaluated on the final bit. This is equivalent to the borrow into the MSB XOR the borrow out.
  - ovf holds until the next completion and resets to 0.
- SERIAL_SUB_OVF_EN undefined: no ovf port and no ovf logic. All other behaviour is identical.

## Structure

- Shared package serial_arith_pkg holds:
  - the state enum (IDLE, RUN, DONE), also reusable by the adder
  - the default width constant
  - the count-width function, $clog2(WIDTH)
- Sub-module serial_full_subtractor: combinational 1-bit cell with inputs a, b, bin and outputs d, bout. It is instantiated once, with the borrow flip-flop kept in the parent.

## Test plan

- Reset, then idle for 20 cycles -> busy=0, done=0, diff=0x000 (ovf=0) throughout.
- operand1=0xC8, operand2=0x37, start pulse -> busy for 8 cycles; done pulse with diff=0x091, borrow 0.
- operand1=0x03, operand2=0x05 -> diff=0x1FE; operand1=0x55, operand2=0x55 -> diff=0x000.
- Start re-pulsed and operands changed to 0xFF/0x00 during RUN of 0x10−0x01 -> ignored; diff=0x00F. With start held high, the next capture happens in the DONE cycle, with no idle gap.
- Reset asserted at RUN bit 4 of 0xC8−0x37 -> busy falls immediately, no done, diff=0x000. A following 0x01−0x01 returns 0x000 with a normal done.
- With SERIAL_SUB_OVF_EN:
  - 0x80−0x01 -> diff=0x07F, ovf=1.
  - 0x7F−0xFF -> diff=0x180, ovf=1.
  - 0x05−0x03 -> diff=0x002, ovf=0.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic blocks (adder, subtractor).
//   state_t       : control FSM states IDLE / RUN / DONE
//   DEFAULT_WIDTH : default operand width
//   cnt_w()       : width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must hold 0..width-1; width >= 2 keeps this at least 1 bit.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Start-driven operand/result bundle for the serial subtractor.
//   start    : request strobe (master -> slave)
//   operand1 : minuend        (master -> slave)
//   operand2 : subtrahend     (master -> slave)
//   busy     : subtraction in progress (slave -> master)
//   done     : one-cycle completion pulse (slave -> master)
//   diff     : {borrow, difference} (slave -> master)
//   ovf      : signed overflow, present only with SERIAL_SUB_OVF_EN
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   diff;

`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, operand1, operand2, input busy, done, diff, ovf);
  modport slave  (input start, operand1, operand2, output busy, done, diff, ovf);
`else
  modport master (output start, operand1, operand2, input busy, done, diff);
  modport slave  (input start, operand1, operand2, output busy, done, diff);
`endif

endinterface

// File: rtl/serial_full_subtractor.sv
// -----------------------------------------------------------------------------
// serial_full_subtractor
// Combinational 1-bit full subtractor cell computing a - b - bin.
//   a, b : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// -----------------------------------------------------------------------------
module serial_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor, LSB first, one bit per clock. Operands are
// captured on start; after WIDTH RUN cycles diff = {borrow, operand1-operand2}
// is registered and done pulses for one cycle.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : serial_subtractor_if.slave (start/operands in, busy/done/diff out)
// Optional: define SERIAL_SUB_OVF_EN to add the registered signed overflow
// flag bus.ovf.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_subtractor_if.slave   bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH:0]   r_diff;

  logic             w_d;
  logic             w_bout;

  serial_full_subtractor u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = RUN;
          w_load = 1'b1;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: requests during RUN are dropped.
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_next = DONE;
          w_last = 1'b1;
        end
      end
      DONE: begin
        // Accepting start here gives back-to-back operation with no idle gap.
        if (bus.start) begin
          w_next = RUN;
          w_load = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_res    <= '0;
      r_diff   <= '0;
    end else if (w_load) begin
      r_a      <= bus.operand1;
      r_b      <= bus.operand2;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_res    <= '0;
    end else if (r_state == RUN) begin
      r_a      <= {1'b0, r_a[WIDTH-1:1]};
      r_b      <= {1'b0, r_b[WIDTH-1:1]};
      r_borrow <= w_bout;
      r_cnt    <= r_cnt + CW'(1);
      r_res    <= {w_d, r_res[WIDTH-1:1]};
      // Final bit: fold the current d and borrow-out straight into the result.
      if (w_last) r_diff <= {w_bout, w_d, r_res[WIDTH-1:1]};
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // On the final bit r_a[0]/r_b[0] are the operand sign bits and w_d is the
  // result sign bit: overflow iff signs differ and the result sign left A's.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_ovf <= 1'b0;
    else if (w_last) r_ovf <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.diff = r_diff;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor: directed vectors, mid-run
// disturbance, held-start back-to-back, asynchronous reset abort, and random
// operands against an arithmetic reference model. Checks ovf when
// SERIAL_SUB_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;
  import serial_arith_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  serial_subtractor_if #(.WIDTH(W)) sif ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: WIDTH+1-bit two's complement of {0,a} - {0,b}.
  function automatic logic [W:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    r  = ia - ib;
    if (r < 0) r = r + (1 << (W + 1));
    return (W + 1)'(r);
  endfunction

  // Reference: signed overflow of a - b interpreted as W-bit two's complement.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    int r;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    r  = sa - sb;
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  // Called at a negedge after the start edge; returns at the negedge where
  // done is high (or after a bounded number of cycles).
  task automatic wait_done(output int n_busy, output logic seen);
    n_busy = 0;
    seen   = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (sif.done) begin
        seen = 1'b1;
      end else begin
        if (sif.busy) n_busy++;
        check("busy_done_excl", 32'(sif.busy & sif.done), 32'd0);
        @(negedge clk);
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int   nb;
    logic seen;
    @(negedge clk);
    sif.operand1 = a;
    sif.operand2 = b;
    sif.start    = 1'b1;
    @(negedge clk);
    sif.start    = 1'b0;
    wait_done(nb, seen);
    check({tag, "_busy_cycles"}, 32'(nb), 32'(W));
    check({tag, "_diff"}, 32'(sif.diff), 32'(ref_diff(a, b)));
    check({tag, "_busy_at_done"}, 32'(sif.busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(sif.ovf), 32'(ref_ovf(a, b)));
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(sif.done), 32'd0);
    check({tag, "_diff_hold"}, 32'(sif.diff), 32'(ref_diff(a, b)));
  endtask

  initial begin
    int   nb;
    int   gap;
    logic seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    sif.start    = 1'b0;
    sif.operand1 = '0;
    sif.operand2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: everything quiet.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(sif.busy), 32'd0);
      check("idle_done", 32'(sif.done), 32'd0);
      check("idle_diff", 32'(sif.diff), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("idle_ovf", 32'(sif.ovf), 32'd0);
`endif
    end

    // Directed vectors with hand-derived constants.
    run_op("c8_37", 8'hC8, 8'h37);
    check("c8_37_const", 32'(sif.diff), 32'h091);
    run_op("03_05", 8'h03, 8'h05);
    check("03_05_const", 32'(sif.diff), 32'h1FE);
    run_op("55_55", 8'h55, 8'h55);
    check("55_55_const", 32'(sif.diff), 32'h000);
    run_op("00_ff", 8'h00, 8'hFF);
    run_op("ff_00", 8'hFF, 8'h00);

    // Disturbance during RUN is ignored; start held high chains the next op.
    @(negedge clk);
    sif.operand1 = 8'h10;
    sif.operand2 = 8'h01;
    sif.start    = 1'b1;
    @(negedge clk);
    sif.start    = 1'b0;
    repeat (2) @(negedge clk);
    sif.operand1 = 8'hFF;
    sif.operand2 = 8'h00;
    sif.start    = 1'b1;
    wait_done(nb, seen);
    check("ign_diff", 32'(sif.diff), 32'h00F);
    gap = 0;
    @(negedge clk);
    gap++;
    check("b2b_busy_no_gap", 32'(sif.busy), 32'd1);
    check("b2b_done_low", 32'(sif.done), 32'd0);
    sif.start = 1'b0;
    for (int i = 0; i < 64 && !sif.done; i++) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_period", 32'(gap), 32'(W + 1));
    check("b2b_diff", 32'(sif.diff), 32'h0FF);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN aborts without a done.
    sif.operand1 = 8'hC8;
    sif.operand2 = 8'h37;
    sif.start    = 1'b1;
    @(negedge clk);
    sif.start    = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(sif.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_done", 32'(sif.done), 32'd0);
    check("rst_diff", 32'(sif.diff), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nb = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (sif.done || sif.busy) nb++;
    end
    check("rst_no_activity", 32'(nb), 32'd0);
    run_op("01_01", 8'h01, 8'h01);
    check("01_01_const", 32'(sif.diff), 32'h000);

`ifdef SERIAL_SUB_OVF_EN
    run_op("ovf_80_01", 8'h80, 8'h01);
    check("ovf_80_01_d", 32'(sif.diff), 32'h07F);
    check("ovf_80_01_o", 32'(sif.ovf), 32'd1);
    run_op("ovf_7f_ff", 8'h7F, 8'hFF);
    check("ovf_7f_ff_d", 32'(sif.diff), 32'h180);
    check("ovf_7f_ff_o", 32'(sif.ovf), 32'd1);
    run_op("ovf_05_03", 8'h05, 8'h03);
    check("ovf_05_03_d", 32'(sif.diff), 32'h002);
    check("ovf_05_03_o", 32'(sif.ovf), 32'd0);
`endif

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ra;
      run_op("rand", ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
